mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4: the number of consecutive data grants allowed while a fetch is waiting.
REQ-002 The block SHALL have the following ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low.
REQ-003 The block SHALL have the following fetch-side ports:
- if_req  input  1  instruction fetch request; held until if_ack.
- if_addr  input  32  fetch address; held stable while if_req.
- if_rdata  output  32  fetched word; valid in the if_ack cycle.
- if_ack  output  1  one-cycle completion pulse.
REQ-004 The block SHALL have the following data-side ports:
- dm_read  input  1  data load request, from MemRead; held until dm_ack.
- dm_write  input  1  data store request, from MemWrite; held until dm_ack.
- dm_addr  input  32  data address.
- dm_wdata  input  32  store data.
- dm_be  input  4  store byte enables.
- dm_rdata  output  32  load data; valid in the dm_ack cycle.
- dm_ack  output  1  one-cycle completion pulse.
REQ-005 The block SHALL have the following memory-side ports:
- mem_req  output  1  transaction active.
- mem_we  output  1  write.
- mem_addr  output  32  memory address.
- mem_wdata  output  32  memory write data.
- mem_be  output  4  memory byte enables.
- mem_rdata  input  32  memory read data.
- mem_ready  input  1  memory completes the current transaction this cycle.

Function
REQ-006 The FSM SHALL have states IDLE, BUSY_IF, BUSY_DM and DONE, all registered.
REQ-007 In IDLE, if no request is present, the FSM SHALL stay in IDLE with mem_req=0.
REQ-008 In IDLE, a data request SHALL be dm_read|dm_write.
REQ-009 In IDLE, when a data request is present, data SHALL win, unless if_req=1 and starve_cnt==STARVE_LIMIT, in which case fetch SHALL win.
REQ-010 In IDLE, if only if_req is present, fetch SHALL win.
REQ-011 On a grant, the winner's address, wdata and be (fetch: be=4'hF, we=0) SHALL be registered onto the mem_* outputs, with mem_req=1 from the next cycle; the state SHALL move to BUSY_IF or BUSY_DM.
REQ-012 When dm_read and dm_write are both high, the request SHALL be treated as a write: mem_we=1, and dm_rdata SHALL hold its previous value.
REQ-013 In BUSY_x, all mem_* outputs SHALL stay constant until mem_ready=1 is sampled.
REQ-014 When mem_ready=1 is sampled in BUSY_x:
- the state SHALL become DONE and mem_req SHALL go to 0;
- mem_rdata SHALL be captured into x_rdata, and x_ack SHALL be 1 for exactly that DONE cycle.
REQ-015 In DONE, no arbitration SHALL occur, and the state SHALL be IDLE on the next cycle. The requester drops or renews its request in the cycle after ack, so no double issue occurs.
REQ-016 Latency: a request sampled in IDLE at cycle 0 SHALL give mem_req=1 at cycle 1; mem_ready at cycle k (k>=1) SHALL give ack at cycle k+1; the earliest next grant SHALL be at cycle k+2.
REQ-017 mem_ready=1 while in IDLE or DONE SHALL be ignored.
REQ-018 starve_cnt (width clog2(STARVE_LIMIT+1)) SHALL behave as follows:
- increment on a data grant while if_req=1;
- clear on any fetch grant;
- clear on a data grant with if_req=0;
- saturate at STARVE_LIMIT.
REQ-019 if_rdata and dm_rdata SHALL hold their values between acks.
REQ-020 if_ack and dm_ack SHALL never both be 1.
REQ-021 mem_req SHALL never be 1 in IDLE or DONE.

Reset
REQ-022 reset=0 SHALL immediately, without waiting for clock, force all of the following to 0:
- state=IDLE, starve_cnt=0;
- mem_req, mem_we, mem_addr, mem_wdata, mem_be;
- if_ack, dm_ack, if_rdata, dm_rdata.
REQ-023 A transaction in flight when reset asserts SHALL be abandoned with no ack.
REQ-024 The first grant after reset deassertion SHALL be evaluated on the first rising edge with reset=1.

Verification
REQ-025 The bench SHALL cover the following scenarios:
- Single fetch: if_req=1, if_addr=0x100, mem_ready on 2nd BUSY cycle with mem_rdata=0xDEADBEEF -> mem_req/mem_addr=0x100 at cycle 1, if_ack with if_rdata=0xDEADBEEF at cycle 3 (one cycle only).
- Store: dm_write=1, dm_addr=0x2000, dm_wdata=0x12345678, dm_be=4'b0011, immediate mem_ready -> mem_we=1, mem_be=0011 for one cycle; dm_ack at cycle 2; dm_rdata unchanged.
- Contention: if_req and dm_read both held continuously with STARVE_LIMIT=4 and memory latency 1 -> grant sequence DM,DM,DM,DM,IF,DM,...; starve_cnt returns to 0 after the IF grant.
- Both dm_read and dm_write high -> mem_we=1; no read data captured.
- Reset mid-operation: reset=0 in BUSY_DM with mem_ready low -> mem_req=0 asynchronously; no dm_ack; after release, a pending request is re-granted starting from IDLE.
- Spurious mem_ready=1 held in IDLE for 3 cycles with no requests -> no ack; all outputs remain 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-outstanding memory port between an
// instruction-fetch requester and a data load/store requester. Data wins by
// default; a waiting fetch is forced through after STARVE_LIMIT consecutive
// data grants.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no transaction; arbitrate between fetch and data requests
// BUSY_IF | fetch transaction on the memory port, waiting for mem_ready
// BUSY_DM | data transaction on the memory port, waiting for mem_ready
// DONE    | ack cycle for the finished transaction; no arbitration
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,

  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_be,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,

  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    DONE    = 2'd3
  } stateT;

  stateT           state;
  logic [CntW-1:0] starveCnt;
  logic            dataReq;
  logic            fetchStarved;

  // Request qualification used by the IDLE arbitration.
  always_comb begin
    dataReq      = dm_read | dm_write;
    fetchStarved = if_req && (starveCnt == CntMax);
  end

  // Arbitration FSM with registered memory-port and requester outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      starveCnt <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      // acks are single-cycle pulses; only a completion below re-asserts one
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (dataReq && !fetchStarved) begin
            state     <= BUSY_DM;
            mem_req   <= 1'b1;
            // read+write together is treated as a store
            mem_we    <= dm_write;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_be    <= dm_be;
            if (!if_req)
              starveCnt <= '0;
            else if (starveCnt != CntMax)
              starveCnt <= starveCnt + 1'b1;
          end else if (if_req) begin
            state     <= BUSY_IF;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_be    <= 4'hF;
            starveCnt <= '0;
          end
        end
        BUSY_IF: begin
          if (mem_ready) begin
            state    <= DONE;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            if_rdata <= mem_rdata;
            if_ack   <= 1'b1;
          end
        end
        BUSY_DM: begin
          if (mem_ready) begin
            state   <= DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            // stores leave the load-data register untouched
            if (!mem_we)
              dm_rdata <= mem_rdata;
            dm_ack  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: reset/idle checks, a table of
// cycle vectors, hand-written contention and mid-flight reset sequences, and
// randomized traffic checked against a timestamp-based reference model.
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_read = 1'b0;
  logic        dm_write = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [3:0]  dm_be = '0;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        ifReq;
    logic [31:0] ifAddr;
    logic        dmRd;
    logic        dmWr;
    logic [31:0] dmAddr;
    logic [31:0] dmWdata;
    logic [3:0]  dmBe;
    logic        rdy;
    logic [31:0] rdata;
    logic        eReq;
    logic        eWe;
    logic [31:0] eAddr;
    logic [31:0] eWdata;
    logic [3:0]  eBe;
    logic        eIfAck;
    logic [31:0] eIfData;
    logic        eDmAck;
    logic [31:0] eDmData;
  } vecT;

  vecT vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idleInputs();
    if_req = 1'b0; if_addr = '0;
    dm_read = 1'b0; dm_write = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
    mem_ready = 1'b0; mem_rdata = '0;
  endtask

  task automatic doReset();
    idleInputs();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // contention bookkeeping
  int  grants;
  int  expCnt;
  bit  expIf;
  bit  prevReq;

  // reference model state: values the DUT should show in the current cycle
  bit          mBusy, mOwnerDm, mWe, mIfAck, mDmAck, nIf, nDm;
  logic [31:0] mAddr, mWdata, mIfData, mDmData;
  logic [3:0]  mBe;
  int          mStarve, allowAt, cyc, k;

  initial begin
    vecs[0]  = '{1, 32'h100, 0, 0, 0, 0, 0,  0, 0,            1, 0, 32'h100, 0, 4'hF,  0, 0,            0, 0};
    vecs[1]  = '{1, 32'h100, 0, 0, 0, 0, 0,  0, 0,            1, 0, 32'h100, 0, 4'hF,  0, 0,            0, 0};
    vecs[2]  = '{1, 32'h100, 0, 0, 0, 0, 0,  1, 32'hDEADBEEF, 0, 0, 0, 0, 0,           1, 32'hDEADBEEF, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 0,        0, 0,            0, 0, 0, 0, 0,           0, 32'hDEADBEEF, 0, 0};
    vecs[4]  = '{0, 0, 0, 0, 0, 0, 0,        0, 0,            0, 0, 0, 0, 0,           0, 32'hDEADBEEF, 0, 0};
    vecs[5]  = '{0, 0, 0, 1, 32'h2000, 32'h12345678, 4'b0011, 0, 0,
                 1, 1, 32'h2000, 32'h12345678, 4'b0011, 0, 32'hDEADBEEF, 0, 0};
    vecs[6]  = '{0, 0, 0, 1, 32'h2000, 32'h12345678, 4'b0011, 1, 32'hCAFEF00D,
                 0, 0, 0, 0, 0,           0, 32'hDEADBEEF, 1, 0};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 0,        0, 0,            0, 0, 0, 0, 0,           0, 32'hDEADBEEF, 0, 0};
    vecs[8]  = '{0, 0, 1, 1, 32'h40, 32'hAA55AA55, 4'hF, 0, 0,
                 1, 1, 32'h40, 32'hAA55AA55, 4'hF, 0, 32'hDEADBEEF, 0, 0};
    vecs[9]  = '{0, 0, 1, 1, 32'h40, 32'hAA55AA55, 4'hF, 1, 32'h5555AAAA,
                 0, 0, 0, 0, 0,           0, 32'hDEADBEEF, 1, 0};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 0,        0, 0,            0, 0, 0, 0, 0,           0, 32'hDEADBEEF, 0, 0};
    vecs[11] = '{0, 0, 1, 0, 32'h80, 0, 4'hF, 0, 0,
                 1, 0, 32'h80, 0, 4'hF,   0, 32'hDEADBEEF, 0, 0};
    vecs[12] = '{0, 0, 1, 0, 32'h80, 0, 4'hF, 1, 32'h0BADF00D,
                 0, 0, 0, 0, 0,           0, 32'hDEADBEEF, 1, 32'h0BADF00D};
    vecs[13] = '{0, 0, 0, 0, 0, 0, 0,        1, 32'hFFFFFFFF, 0, 0, 0, 0, 0,           0, 32'hDEADBEEF, 0, 32'h0BADF00D};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 0,        1, 32'hFFFFFFFF, 0, 0, 0, 0, 0,           0, 32'hDEADBEEF, 0, 32'h0BADF00D};

    // ---- reset values, then spurious mem_ready while idle ----
    #1;
    doReset();
    chk("reset ctrl", 32'({mem_req, mem_we, mem_be, if_ack, dm_ack}), 32'h0);
    chk("reset data", mem_addr | mem_wdata | if_rdata | dm_rdata, 32'h0);
    chk("reset starve", 32'(dut.starveCnt), 32'h0);
    mem_ready = 1'b1;
    mem_rdata = 32'h13579BDF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("spurious%0d ctrl", i), 32'({mem_req, mem_we, mem_be, if_ack, dm_ack}), 32'h0);
      chk($sformatf("spurious%0d data", i), mem_addr | mem_wdata | if_rdata | dm_rdata, 32'h0);
    end

    // ---- vector table: single fetch, store, read+write, load ----
    for (int i = 0; i < 15; i++) begin
      if_req = vecs[i].ifReq;   if_addr = vecs[i].ifAddr;
      dm_read = vecs[i].dmRd;   dm_write = vecs[i].dmWr;
      dm_addr = vecs[i].dmAddr; dm_wdata = vecs[i].dmWdata; dm_be = vecs[i].dmBe;
      mem_ready = vecs[i].rdy;  mem_rdata = vecs[i].rdata;
      tick();
      chk($sformatf("vec%0d mem_req", i), 32'(mem_req), 32'(vecs[i].eReq));
      if (vecs[i].eReq) begin
        chk($sformatf("vec%0d mem_we", i), 32'(mem_we), 32'(vecs[i].eWe));
        chk($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].eAddr);
        chk($sformatf("vec%0d mem_be", i), 32'(mem_be), 32'(vecs[i].eBe));
        if (vecs[i].eWe)
          chk($sformatf("vec%0d mem_wdata", i), mem_wdata, vecs[i].eWdata);
      end
      chk($sformatf("vec%0d if_ack", i), 32'(if_ack), 32'(vecs[i].eIfAck));
      chk($sformatf("vec%0d if_rdata", i), if_rdata, vecs[i].eIfData);
      chk($sformatf("vec%0d dm_ack", i), 32'(dm_ack), 32'(vecs[i].eDmAck));
      chk($sformatf("vec%0d dm_rdata", i), dm_rdata, vecs[i].eDmData);
    end

    // ---- contention: both requesters held, one-cycle memory ----
    doReset();
    if_req = 1'b1; if_addr = 32'h1000;
    dm_read = 1'b1; dm_addr = 32'h2000; dm_be = 4'hF;
    mem_ready = 1'b1; mem_rdata = 32'h0;
    grants = 0; expCnt = 0; prevReq = 1'b0;
    for (int c = 0; c < 60 && grants < 6; c++) begin
      tick();
      chk("contention acks exclusive", 32'(if_ack & dm_ack), 32'h0);
      if (mem_req && !prevReq) begin
        expIf = (expCnt == LIMIT);
        expCnt = expIf ? 0 : expCnt + 1;
        chk($sformatf("contention grant%0d is_fetch", grants), 32'(mem_addr == 32'h1000), 32'(expIf));
        chk($sformatf("contention grant%0d starve", grants), 32'(dut.starveCnt), 32'(expCnt));
        grants++;
      end
      prevReq = mem_req;
    end
    if (grants < 6) begin
      errors++; checks++;
      $display("FAIL contention timeout: got %0d grants expected 6", grants);
    end

    // ---- reset while a load is in flight ----
    doReset();
    dm_read = 1'b1; dm_addr = 32'h3000; dm_be = 4'hF;
    tick();
    chk("midreset granted", 32'(mem_req), 32'h1);
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("midreset async mem_req", 32'(mem_req), 32'h0);
    chk("midreset async mem_addr", mem_addr, 32'h0);
    tick();
    chk("midreset no ack", 32'(dm_ack), 32'h0);
    chk("midreset held req", 32'(mem_req), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    chk("midreset regrant req", 32'(mem_req), 32'h1);
    chk("midreset regrant addr", mem_addr, 32'h3000);
    mem_ready = 1'b1; mem_rdata = 32'h600DCAFE;
    tick();
    chk("midreset ack", 32'(dm_ack), 32'h1);
    chk("midreset rdata", dm_rdata, 32'h600DCAFE);

    // ---- randomized traffic against the reference model ----
    doReset();
    mBusy = 0; mOwnerDm = 0; mWe = 0; mIfAck = 0; mDmAck = 0;
    mAddr = '0; mWdata = '0; mBe = '0; mIfData = '0; mDmData = '0;
    mStarve = 0; allowAt = 0; cyc = 0;
    for (int c = 0; c < 1500; c++) begin
      chk("rnd mem_req", 32'(mem_req), 32'(mBusy));
      if (mBusy) begin
        chk("rnd mem_we", 32'(mem_we), 32'(mWe));
        chk("rnd mem_addr", mem_addr, mAddr);
        chk("rnd mem_be", 32'(mem_be), 32'(mBe));
        if (mWe) chk("rnd mem_wdata", mem_wdata, mWdata);
      end
      chk("rnd if_ack", 32'(if_ack), 32'(mIfAck));
      chk("rnd dm_ack", 32'(dm_ack), 32'(mDmAck));
      chk("rnd if_rdata", if_rdata, mIfData);
      chk("rnd dm_rdata", dm_rdata, mDmData);

      // requesters hold until acked, then drop or renew
      if (!if_req || mIfAck) begin
        if_req = ($urandom_range(0, 2) != 0);
        if_addr = $urandom;
      end
      if (!(dm_read || dm_write) || mDmAck) begin
        k = $urandom_range(0, 4);
        dm_read = (k == 2) || (k == 4);
        dm_write = (k == 3) || (k == 4);
        dm_addr = $urandom; dm_wdata = $urandom; dm_be = 4'($urandom_range(0, 15));
      end
      mem_ready = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;

      // what the next cycle should look like
      nIf = 0; nDm = 0;
      if (mBusy) begin
        if (mem_ready) begin
          mBusy = 0;
          allowAt = cyc + 2;
          if (mOwnerDm) begin
            nDm = 1;
            if (!mWe) mDmData = mem_rdata;
          end else begin
            nIf = 1;
            mIfData = mem_rdata;
          end
        end
      end else if (cyc >= allowAt) begin
        if ((dm_read || dm_write) && !(if_req && mStarve == LIMIT)) begin
          mBusy = 1; mOwnerDm = 1; mWe = dm_write;
          mAddr = dm_addr; mWdata = dm_wdata; mBe = dm_be;
          mStarve = if_req ? ((mStarve + 1 > LIMIT) ? LIMIT : mStarve + 1) : 0;
        end else if (if_req) begin
          mBusy = 1; mOwnerDm = 0; mWe = 0;
          mAddr = if_addr; mBe = 4'hF;
          mStarve = 0;
        end
      end
      mIfAck = nIf;
      mDmAck = nDm;
      cyc++;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
